psram_xfer_engine: RTL and testbench



---
 rtl/psram_pkg.sv | 11 +
 rtl/psram_clkdiv.sv | 34 +++
 rtl/psram_xfer_engine.sv | 130 +++++++++++++
 tb/tb_psram_xfer_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: shared state encoding, phase bit lengths and lane widths for the PSRAM transfer engine.
package psram_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DATA, HOLD} state_e;
  localparam logic [7:0] CMD_BITS = 8'd8;
  localparam logic [7:0] ADDR_BITS = 8'd24;
  localparam int SPI_LANES = 1;
  localparam int QUAD_LANES = 4;
  function automatic logic [7:0] sck_cycles(input logic [7:0] bits, input logic quad);
    return quad ? bits >> $clog2(QUAD_LANES) : bits >> $clog2(SPI_LANES);
  endfunction
endpackage

// File: rtl/psram_clkdiv.sv
// psram_clkdiv: half-period counter producing SCK plus tick/rise/fall strobes for the edge about to happen.
module psram_clkdiv (
  input  logic       pclk,
  input  logic       prst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       gate_i,
  input  logic [7:0] div_i,
  output logic       sck_o,
  output logic       tick_o,
  output logic       rise_o,
  output logic       fall_o
);
  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  // gate_i only blocks new rising edges, so a pending fall always completes
  always_comb begin
    tick_o = en_i && cnt_q == div_i;
    rise_o = tick_o && gate_i && !sck_q;
    fall_o = tick_o && sck_q;
    cnt_d  = (clr_i || tick_o) ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
    sck_d  = clr_i ? 1'b0 : (rise_o || fall_o) ? ~sck_q : sck_q;
  end
  always_ff @(posedge pclk) begin
    if (prst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end
  assign sck_o = sck_q;
endmodule

// File: rtl/psram_xfer_engine.sv
// psram_xfer_engine: one CE-framed PSRAM transaction (cmd, 24-bit addr, dummy cycles, 1-4 data bytes).
// Define PSRAM_QUAD_EN to compile in the 4-bit lane datapath; otherwise quad_i is ignored.
module psram_xfer_engine
  import psram_pkg::*;
#(
  parameter int CE_HOLD = 2
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        start_i,
  input  logic [7:0]  div_i,
  input  logic [7:0]  cmd_i,
  input  logic [23:0] addr_i,
  input  logic [4:0]  wait_i,
  input  logic        wr_i,
  input  logic [1:0]  len_i,
  input  logic        quad_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        psram_sck_o,
  output logic        psram_ce_n_o,
  output logic [3:0]  psram_io_o,
  output logic [3:0]  psram_io_en_o,
  input  logic [3:0]  psram_io_i
);
  state_e      state_q, state_d;
  logic [7:0]  div_q, cnt_q, cnt_d, plen;
  logic [4:0]  wait_q;
  logic [1:0]  len_q;
  logic        wr_q, quad_q, quad_s;
  logic [31:0] wdata_q, sh_q, sh_d, rx_q, rx_d, rx_sh, rdata_q;
  logic [3:0]  lanes, lane_en;
  logic        go, tick, rise, fall, phase_end, drive;
`ifdef PSRAM_QUAD_EN
  assign quad_s  = quad_i;
  assign rx_sh   = quad_q ? {rx_q[27:0], psram_io_i} : {rx_q[30:0], psram_io_i[1]};
  assign lanes   = quad_q ? sh_q[31:28] : {3'b000, sh_q[31]};
  assign lane_en = quad_q ? 4'hF : 4'h1;
`else
  logic unused_quad;
  assign unused_quad = ^{quad_i, psram_io_i[3:2], psram_io_i[0]};
  assign quad_s  = 1'b0;
  assign rx_sh   = {rx_q[30:0], psram_io_i[1]};
  assign lanes   = {3'b000, sh_q[31]};
  assign lane_en = 4'h1;
`endif
  psram_clkdiv u_clkdiv (
    .pclk   (pclk),
    .prst   (prst),
    .en_i   (state_q != IDLE),
    .clr_i  (go),
    .gate_i (state_q != HOLD),
    .div_i  (div_q),
    .sck_o  (psram_sck_o),
    .tick_o (tick),
    .rise_o (rise),
    .fall_o (fall)
  );
  // phases end on a falling edge, which is also where the next phase's first bit appears
  always_comb begin
    go        = state_q == IDLE && start_i;
    plen      = state_q == CMD  ? sck_cycles(CMD_BITS, quad_q)
              : state_q == ADDR ? sck_cycles(ADDR_BITS, quad_q)
              : state_q == WAIT ? {3'b000, wait_q}
              : sck_cycles({2'b00, 3'({1'b0, len_q} + 3'd1), 3'b000}, quad_q);
    phase_end = fall && cnt_q == plen - 8'd1;
  end
  always_ff @(posedge pclk) begin
    if (prst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_i ? CMD : IDLE;
      CMD:     state_d = phase_end ? ADDR : CMD;
      ADDR:    state_d = !phase_end ? ADDR : (!wr_q && wait_q != 5'd0) ? WAIT : DATA;
      WAIT:    state_d = phase_end ? DATA : WAIT;
      DATA:    state_d = phase_end ? HOLD : DATA;
      HOLD:    state_d = done_o ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // in HOLD the counter counts half-periods; the first one keeps CE low after the last fall
  always_comb begin
    busy_o        = state_q != IDLE;
    done_o        = state_q == HOLD && tick && cnt_q == 8'(CE_HOLD);
    psram_ce_n_o  = state_q == IDLE || (state_q == HOLD && cnt_q != 8'd0);
    drive         = state_q == CMD || state_q == ADDR || (state_q == DATA && wr_q);
    psram_io_o    = drive ? lanes : 4'h0;
    psram_io_en_o = drive ? lane_en : 4'h0;
    rdata_o       = done_o ? rx_q : rdata_q;
  end
  always_comb begin
    cnt_d = (go || phase_end) ? 8'd0 : (state_q == HOLD ? tick : fall) ? cnt_q + 8'd1 : cnt_q;
    sh_d  = go ? {cmd_i, addr_i}
          : (phase_end && state_d == DATA) ? wdata_q
          : fall ? (quad_q ? {sh_q[27:0], 4'h0} : {sh_q[30:0], 1'b0}) : sh_q;
    rx_d  = go ? 32'd0 : (rise && state_q == DATA && !wr_q) ? rx_sh : rx_q;
  end
  always_ff @(posedge pclk) begin
    if (prst) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      div_q   <= '0;
      wait_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      quad_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_o;
      if (go) begin
        div_q   <= div_i;
        wait_q  <= wait_i;
        len_q   <= len_i;
        wr_q    <= wr_i;
        quad_q  <= quad_s;
        wdata_q <= wdata_i;
      end
    end
  end
endmodule

// File: tb/tb_psram_xfer_engine.sv
// tb_psram_xfer_engine: scoreboard bench with a bit-level PSRAM pin model and SCK/CE timing monitor.
`timescale 1ns/1ps
module tb_psram_xfer_engine;
`ifdef PSRAM_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif
  localparam int CE_HOLD = 2;
  logic        pclk = 1'b0, prst = 1'b1, start_i = 1'b0, wr_i = 1'b0, quad_i = 1'b0;
  logic [7:0]  div_i = '0, cmd_i = '0;
  logic [23:0] addr_i = '0;
  logic [4:0]  wait_i = '0;
  logic [1:0]  len_i = '0;
  logic [31:0] wdata_i = '0, rdata_o;
  logic        busy_o, done_o, psram_sck_o, psram_ce_n_o;
  logic [3:0]  psram_io_o, psram_io_en_o, psram_io_i;

  psram_xfer_engine #(.CE_HOLD(CE_HOLD)) dut (
    .pclk(pclk), .prst(prst), .start_i(start_i), .div_i(div_i), .cmd_i(cmd_i),
    .addr_i(addr_i), .wait_i(wait_i), .wr_i(wr_i), .len_i(len_i), .quad_i(quad_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o),
    .psram_sck_o(psram_sck_o), .psram_ce_n_o(psram_ce_n_o), .psram_io_o(psram_io_o),
    .psram_io_en_o(psram_io_en_o), .psram_io_i(psram_io_i)
  );
  always #5 pclk = ~pclk;

  typedef struct {
    logic [63:0] stream;
    logic [31:0] rdata;
    logic        chk_rd;
    int          rises;
    int          hold;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // current transaction as seen by the pin model
  logic        md_quad = 1'b0, md_wr = 1'b0;
  int          md_div = 0, md_pre = 32, md_nb = 8;
  logic [31:0] md_word = '0;

  function automatic logic [3:0] exp_en(input int k);
    logic [3:0] lane = md_quad ? 4'hF : 4'h1;
    return (k <= (md_quad ? 8 : 32) || md_wr) ? lane : 4'h0;
  endfunction

  function automatic logic [3:0] model_nib(input int idx);
    logic b;
    if (md_quad) return (idx < md_nb / 4) ? 4'(md_word >> (md_nb - 4 * (idx + 1))) : 4'h0;
    if (idx >= md_nb) return 4'h0;
    b = md_word[md_nb - 1 - idx];
    return {~b, ~b, b, ~b};
  endfunction

  logic        prev_sck = 1'b0, prev_ce = 1'b1;
  int          rises = 0, falls = 0, run = 0, hi_run = 0, en_err = 0, ph_err = 0, ndone = 0;
  logic [63:0] stream = '0;

  always @(negedge pclk) begin : mon
    exp_t e;
    if (prst) psram_io_i = 4'h0;
    if (prev_ce && !psram_ce_n_o) begin
      rises = 0; falls = 0; run = 0; en_err = 0; ph_err = 0; stream = '0;
    end
    if (!psram_ce_n_o) begin
      if (psram_sck_o != prev_sck) begin
        if (run != md_div + 1) ph_err++;
        run = 1;
        if (psram_sck_o) begin
          rises++;
          if (psram_io_en_o != exp_en(rises)) en_err++;
          if (!md_quad && psram_io_o[3:1] != 3'b000) en_err++;
          if (psram_io_en_o != 4'h0)
            stream = md_quad ? {stream[59:0], psram_io_o} : {stream[62:0], psram_io_o[0]};
        end else begin
          falls++;
          if (falls >= md_pre) psram_io_i = model_nib(falls - md_pre);
        end
      end else run++;
      hi_run = 0;
    end else begin
      if (!prev_ce && run != md_div + 1) ph_err++;
      run = 0;
      hi_run++;
    end
    if (done_o) begin
      ndone++;
      if (sb.size() == 0) check("spurious_done", done_o, 0);
      else begin
        e = sb.pop_front();
        check("sck_rises", rises, e.rises);
        check("io_stream", stream, e.stream);
        check("io_en", en_err, 0);
        check("sck_phase", ph_err, 0);
        check("ce_hold", hi_run, e.hold);
        if (e.chk_rd) check("rdata", rdata_o, e.rdata);
      end
    end
    prev_sck = psram_sck_o;
    prev_ce  = psram_ce_n_o;
  end

  int exp_done = 0;

  task automatic start_xfer(input logic [7:0] d, input logic [7:0] c, input logic [23:0] a,
                            input logic [4:0] w, input logic wr, input logic [1:0] l,
                            input logic q, input logic [31:0] wd, input logic [31:0] mw);
    exp_t e;
    int   nb = (int'(l) + 1) * 8;
    logic qe = q & QUAD;
    int   we = wr ? 0 : int'(w);
    e.rises  = qe ? 8 + we + nb / 4 : 32 + we + nb;
    e.stream = wr ? (({32'b0, c, a} << nb) | 64'(wd >> (32 - nb))) : {32'b0, c, a};
    e.rdata  = (nb == 32) ? mw : mw & ((32'd1 << nb) - 32'd1);
    e.chk_rd = !wr;
    e.hold   = CE_HOLD * (int'(d) + 1);
    md_quad = qe; md_wr = wr; md_div = int'(d); md_pre = (qe ? 8 : 32) + we; md_nb = nb; md_word = mw;
    div_i = d; cmd_i = c; addr_i = a; wait_i = w; wr_i = wr; len_i = l; quad_i = q; wdata_i = wd;
    start_i = 1'b1;
    sb.push_back(e);
    @(negedge pclk);
    start_i = 1'b0;
    check("start_ack", {busy_o, psram_ce_n_o}, 2'b10);
    {div_i, cmd_i, addr_i, wait_i, wr_i, len_i, quad_i, wdata_i} = 81'({$urandom, $urandom, $urandom});
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    @(negedge pclk);
    while (!done_o && k < budget) begin
      @(negedge pclk);
      k++;
    end
    check("done_seen", done_o, 1);
    exp_done++;
    @(negedge pclk);
    check("idle_after_done", {busy_o, psram_ce_n_o}, 2'b01);
  endtask

  initial begin
    start_i = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      check("reset_pins", {psram_ce_n_o, psram_sck_o, psram_io_en_o, busy_o, done_o}, 8'b1000_0000);
    end
    check("reset_rdata", rdata_o, 0);
    start_i = 1'b0;
    prst = 1'b0;
    @(negedge pclk);
    start_xfer(8'd0, 8'h38, 24'h123456, 5'd3, 1'b1, 2'd0, 1'b0, 32'hA55A3C96, 32'h0);
    wait_done(2000);
    start_xfer(8'd0, 8'h0B, 24'hABCDEF, 5'd8, 1'b0, 2'd3, 1'b0, 32'h0, 32'hDEADBEEF);
    wait_done(2000);
    start_xfer(8'd1, 8'h03, 24'h000001, 5'd0, 1'b0, 2'd0, 1'b1, 32'h0, 32'h000000C3);
    wait_done(2000);
`ifdef PSRAM_QUAD_EN
    start_xfer(8'd0, 8'hEB, 24'h00F0F0, 5'd6, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000CAFE);
    wait_done(2000);
    start_xfer(8'd2, 8'h38, 24'h654321, 5'd4, 1'b1, 2'd2, 1'b1, 32'h11223344, 32'h0);
    wait_done(2000);
`endif
    start_xfer(8'd3, 8'h02, 24'h0000FF, 5'd0, 1'b1, 2'd1, 1'b0, 32'hBEEF0000, 32'h0);
    repeat (60) @(negedge pclk);
    cmd_i = 8'hFF;
    start_i = 1'b1;
    @(negedge pclk);
    start_i = 1'b0;
    wait_done(5000);
    repeat (50) @(negedge pclk);
    check("ignored_start_idle", {busy_o, psram_ce_n_o}, 2'b01);
    start_xfer(8'd0, 8'h0B, 24'h111111, 5'd0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h12345678);
    for (int k = 0; k < 500 && rises < 36; k++) @(negedge pclk);
    check("reach_data", rises >= 36, 1);
    prst = 1'b1;
    @(negedge pclk);
    prst = 1'b0;
    sb.delete();
    check("abort_pins", {psram_ce_n_o, psram_sck_o, psram_io_en_o, busy_o, done_o}, 8'b1000_0000);
    check("abort_rdata", rdata_o, 0);
    @(negedge pclk);
    start_xfer(8'd0, 8'h0B, 24'h222222, 5'd2, 1'b0, 2'd2, 1'b0, 32'h0, 32'h00ABCDEF);
    wait_done(2000);
    repeat (5) @(negedge pclk);
    check("rdata_hold", rdata_o, 32'h00ABCDEF);
    check("done_count", ndone, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
